// File: rtl/u2_onehot_encoder.sv
// Two's-complement operand to offset one-hot encoder with range/sign flags,
// a 2-entry valid/ready output FIFO and a saturating out-of-range counter.
module u2_onehot_encoder #(
  parameter int WIDTH = 4,
  parameter int LEN   = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_A,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [LEN-1:0]   o_Y,
  output logic             o_err,
  output logic             o_neg,
  output logic             o_pos,
  output logic [7:0]       o_err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [LEN-1:0] y;
    logic           err;
    logic           neg;
    logic           pos;
  } entry_t;

  localparam logic signed [WIDTH:0] HALF = (WIDTH+1)'(LEN / 2);

  state_t state, state_next;
  entry_t mem [2];
  entry_t enc;
  entry_t head;
  logic   wptr, rptr;
  logic   wr, rd;
  logic   in_range;
  logic signed [WIDTH:0] ext;
  logic signed [WIDTH:0] idx;

  // Sign-extend one bit so the offset add and range compare never wrap.
  assign ext      = {i_A[WIDTH-1], i_A};
  assign idx      = ext + HALF;
  assign in_range = (ext >= -HALF) && (ext <= HALF - 1);

  always_comb begin
    enc     = '0;
    enc.err = !in_range;
    enc.neg = i_A[WIDTH-1];
    enc.pos = !i_A[WIDTH-1] && (i_A != '0);
    for (int unsigned i = 0; i < LEN; i++) begin
      enc.y[i] = in_range && (unsigned'(idx) == (WIDTH+1)'(i));
    end
  end

  assign o_READY = (state != FULL) && !i_RST;
  assign o_VALID = (state != EMPTY);
  assign wr      = i_VALID && o_READY;
  assign rd      = o_VALID && i_READY;

  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY:   if (wr) state_next = ONE;
      ONE:     if (wr && !rd) state_next = FULL;
               else if (rd && !wr) state_next = EMPTY;
      FULL:    if (rd) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= EMPTY;
      wptr      <= 1'b0;
      rptr      <= 1'b0;
      o_err_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      state <= state_next;
      if (wr) begin
        mem[wptr] <= enc;
        wptr      <= ~wptr;
        if (!in_range && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
      end
      if (rd) rptr <= ~rptr;
    end
  end

  assign head  = o_VALID ? mem[rptr] : '0;
  assign o_Y   = head.y;
  assign o_err = head.err;
  assign o_neg = head.neg;
  assign o_pos = head.pos;

endmodule

// File: tb/tb_u2_onehot_encoder.sv
// Scoreboard bench for u2_onehot_encoder (WIDTH=4, LEN=8) with directed vectors.
module tb_u2_onehot_encoder;

  typedef struct packed {
    logic [7:0] y;
    logic       err;
    logic       neg;
    logic       pos;
  } exp_t;

  logic       i_CLK = 1'b0;
  logic       i_RST = 1'b1;
  logic [3:0] i_A = '0;
  logic       i_VALID = 1'b0;
  logic       i_READY = 1'b0;
  logic       o_READY, o_VALID, o_err, o_neg, o_pos;
  logic [7:0] o_Y, o_err_cnt;

  int   errors = 0;
  int   checks = 0;
  int   pops   = 0;
  exp_t sb[$];

  u2_onehot_encoder #(.WIDTH(4), .LEN(8)) dut (
    .i_CLK(i_CLK), .i_RST(i_RST), .i_A(i_A), .i_VALID(i_VALID),
    .o_READY(o_READY), .o_VALID(o_VALID), .i_READY(i_READY),
    .o_Y(o_Y), .o_err(o_err), .o_neg(o_neg), .o_pos(o_pos),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_CLK = ~i_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expected result per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_CLK);
      if (o_VALID && i_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %0h with empty scoreboard", {o_Y, o_err, o_neg, o_pos});
        end else begin
          e = sb.pop_front();
          pops++;
          if ({o_Y, o_err, o_neg, o_pos} !== e) begin
            errors++;
            $display("FAIL head_output: got y=%b e/n/p=%b%b%b expected y=%b e/n/p=%b%b%b",
                     o_Y, o_err, o_neg, o_pos, e.y, e.err, e.neg, e.pos);
          end
        end
      end
    end
  end

  task automatic send(input logic [3:0] a, input exp_t e);
    int unsigned n = 0;
    i_A = a;
    i_VALID = 1'b1;
    @(negedge i_CLK);
    while (!o_READY && n < 50) begin
      @(negedge i_CLK);
      n++;
    end
    if (!o_READY) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: o_READY=%b expected 1 for operand %h", o_READY, a);
    end else begin
      sb.push_back(e);
    end
    @(posedge i_CLK);
    #1;
    i_VALID = 1'b0;
  endtask

  logic [3:0] stream_a [10] = '{4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 4'h2};
  exp_t       stream_e [10] = '{
    '{8'h01, 1'b0, 1'b1, 1'b0}, '{8'h02, 1'b0, 1'b1, 1'b0},
    '{8'h04, 1'b0, 1'b1, 1'b0}, '{8'h08, 1'b0, 1'b1, 1'b0},
    '{8'h10, 1'b0, 1'b0, 1'b0}, '{8'h20, 1'b0, 1'b0, 1'b1},
    '{8'h40, 1'b0, 1'b0, 1'b1}, '{8'h80, 1'b0, 1'b0, 1'b1},
    '{8'h08, 1'b0, 1'b1, 1'b0}, '{8'h40, 1'b0, 1'b0, 1'b1}
  };

  initial begin
    int p0;
    #3;
    chk("rst_ready", o_READY, 0);
    chk("rst_valid", o_VALID, 0);
    chk("rst_y", o_Y, 0);
    chk("rst_flags", {o_err, o_neg, o_pos}, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    @(posedge i_CLK); @(posedge i_CLK); #1;
    i_RST = 1'b0;
    #1;
    chk("ready_after_rst", o_READY, 1);
    @(posedge i_CLK); #1;

    // Directed single operands, consumer always ready.
    i_READY = 1'b1;
    send(4'hD, '{8'h02, 1'b0, 1'b1, 1'b0});
    @(negedge i_CLK);
    chk("latency_valid", o_VALID, 1);
    @(posedge i_CLK); #1;
    send(4'hC, '{8'h01, 1'b0, 1'b1, 1'b0});
    send(4'h3, '{8'h80, 1'b0, 1'b0, 1'b1});
    send(4'h0, '{8'h10, 1'b0, 1'b0, 1'b0});
    send(4'h4, '{8'h00, 1'b1, 1'b0, 1'b1});
    send(4'hB, '{8'h00, 1'b1, 1'b1, 1'b0});
    @(posedge i_CLK); #1;
    chk("err_cnt_two", o_err_cnt, 2);
    chk("drained_valid", o_VALID, 0);

    // Back-pressure: two writes fill, third held upstream.
    i_READY = 1'b0;
    send(4'h1, '{8'h20, 1'b0, 1'b0, 1'b1});
    send(4'h2, '{8'h40, 1'b0, 1'b0, 1'b1});
    i_A = 4'h3;
    i_VALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_CLK);
      chk("bp_ready_low", o_READY, 0);
      chk("bp_head_stable", {o_VALID, o_Y}, {1'b1, 8'h20});
    end
    @(posedge i_CLK); #1;
    i_READY = 1'b1;
    send(4'h3, '{8'h80, 1'b0, 1'b0, 1'b1});
    @(posedge i_CLK); #1;
    @(posedge i_CLK); #1;
    chk("bp_drained", sb.size(), 0);

    // Streaming: simultaneous read/write each cycle in ONE.
    p0 = pops;
    for (int k = 0; k < 10; k++) begin
      i_A = stream_a[k];
      i_VALID = 1'b1;
      @(negedge i_CLK);
      chk("stream_ready", o_READY, 1);
      if (k > 0) chk("stream_valid", o_VALID, 1);
      sb.push_back(stream_e[k]);
      @(posedge i_CLK); #1;
    end
    i_VALID = 1'b0;
    @(posedge i_CLK); #1;
    chk("stream_pops", pops - p0, 10);
    chk("stream_empty", o_VALID, 0);

    // Asynchronous reset while FULL.
    i_READY = 1'b0;
    send(4'h1, '{8'h20, 1'b0, 1'b0, 1'b1});
    send(4'h2, '{8'h40, 1'b0, 1'b0, 1'b1});
    @(negedge i_CLK);
    chk("full_ready", o_READY, 0);
    #2;
    i_RST = 1'b1;
    sb.delete();
    #1;
    chk("arst_valid", o_VALID, 0);
    chk("arst_ready", o_READY, 0);
    chk("arst_y", o_Y, 0);
    chk("arst_err_cnt", o_err_cnt, 0);
    @(negedge i_CLK); #1;
    i_RST = 1'b0;
    #1;
    chk("arst_ready_after", o_READY, 1);
    @(posedge i_CLK); #1;
    i_READY = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_CLK);
      chk("no_stale", o_VALID, 0);
    end
    @(posedge i_CLK); #1;

    // Saturation of the out-of-range counter.
    for (int k = 0; k < 300; k++) begin
      if (k % 2 == 0) send(4'h4, '{8'h00, 1'b1, 1'b0, 1'b1});
      else            send(4'h8, '{8'h00, 1'b1, 1'b1, 1'b0});
      if (k == 254) chk("err_cnt_255", o_err_cnt, 255);
    end
    @(posedge i_CLK); #1;
    @(posedge i_CLK); #1;
    chk("err_cnt_sat", o_err_cnt, 255);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/u2_onehot_encoder.md
# u2_onehot_encoder

Converts a two's-complement (U2) operand into an offset one-hot code and is the encoding counterpart of the ALU's one-hot-to-U2 decoder path. Operands arrive over a valid/ready handshake, are range-checked and encoded, then queued in a 2-entry output FIFO that drives a downstream valid/ready consumer, typically the ALU's `i_A`/`i_B` operand port. The block also sets sign flags and keeps a saturating count of out-of-range operands.

## Interface
- `WIDTH`, default 4: U2 input width in bits; must be ≥ 2.
- `LEN`, default 8: one-hot output width. Must be even, ≥ 2, and ≤ 2**WIDTH.
- `i_CLK`  in  1  clock; all state updates on the rising edge.
- `i_RST`  in  1  reset; one clock, reset asynchronous and active-high. Clears all state immediately.
- `i_A`  in  WIDTH  U2 operand.
- `i_VALID`  in  1  upstream operand valid.
- `o_READY`  out  1  block can accept an operand this cycle.
- `o_VALID`  out  1  FIFO head holds a result.
- `i_READY`  in  1  downstream accepts the head this cycle.
- `o_Y`  out  LEN  one-hot code at the FIFO head.
- `o_err`  out  1  head operand was out of range.
- `o_neg`  out  1  head operand < 0.
- `o_pos`  out  1  head operand > 0.
- `o_err_cnt`  out  8  saturating count of accepted out-of-range operands.

## Operation
- The valid range is −LEN/2 … LEN/2−1 (signed). The one-hot index is `value + LEN/2`, computed in WIDTH+1-bit signed arithmetic so that no intermediate wraps.
- For an in-range operand, `o_Y` has exactly the bit at the index set and `o_err` = 0.
- For an out-of-range operand, `o_Y` is all zeros and `o_err` = 1.
- `o_neg` and `o_pos` are derived from the operand itself, whether or not it is in range. A zero operand gives `o_neg` = `o_pos` = 0.
- Encoding is combinational at the FIFO write. Each FIFO entry stores {`o_Y`, `o_err`, `o_neg`, `o_pos`}.
- Write condition: `i_VALID && o_READY`. Read condition: `o_VALID && i_READY`.
- The FIFO has 2 entries, with read/write pointers and a 2-bit count (0, 1, 2). The count state is the state machine:
  - EMPTY (count 0): `o_VALID` = 0, `o_READY` = 1.
  - ONE (count 1): `o_VALID` = 1, `o_READY` = 1.
  - FULL (count 2): `o_VALID` = 1, `o_READY` = 0.
- Count transitions: write only → +1; read only → −1; write and read in the same cycle (only possible in ONE) → count unchanged, and the pointers advance with wrap-around.
- `o_READY` = (count ≠ 2) and not in reset. It never depends combinationally on `i_READY`.
- When `o_VALID` = 0, `o_Y`, `o_err`, `o_neg` and `o_pos` are forced to 0.
- `o_err_cnt` increments on each write with an out-of-range operand and saturates at 255.
- While `o_VALID` = 1 and `i_READY` = 0, all head outputs stay stable.

## Timing
- Reset values (asynchronous, while `i_RST` = 1): count 0, pointers 0, `o_VALID` 0, `o_READY` 0, `o_Y` 0, `o_err` 0, `o_neg` 0, `o_pos` 0, `o_err_cnt` 0.
- After reset: `o_READY` goes to 1 combinationally once `i_RST` deasserts.
- Reset mid-operation discards all queued entries. No partial handshake completes in the reset cycle.
- Latency: an operand accepted at edge N is visible at the head after edge N, with `o_VALID` = 1 in cycle N+1.
- Throughput: 1 operand per cycle while the consumer holds `i_READY` high.
- Back-pressure: with `i_READY` held at 0, two writes fill the FIFO and `o_READY` drops in the following cycle. The first read frees a slot, and `o_READY` rises in the cycle after that read.
- Ordering: results leave in strict FIFO order.

## Test plan
- WIDTH=4, LEN=8. Send `i_A` = 4'b1101 (−3) with `i_READY` = 1 → the next cycle shows `o_VALID` = 1, `o_Y` = 8'b0000_0010, `o_neg` = 1, `o_pos` = 0, `o_err` = 0.
- Boundaries:
  - 4'b1100 (−4) → `o_Y` = 8'b0000_0001.
  - 4'b0011 (3) → `o_Y` = 8'b1000_0000, `o_pos` = 1.
  - 4'b0000 (0) → `o_Y` = 8'b0001_0000, with `o_neg` = `o_pos` = 0.
- Out of range:
  - 4'b0100 (4) → `o_Y` = 0, `o_err` = 1, `o_pos` = 1.
  - 4'b1011 (−5) → `o_Y` = 0, `o_err` = 1, `o_neg` = 1.
  - After both, `o_err_cnt` = 2.
- Back-pressure: hold `i_READY` = 0 and send 1, 2, 3 back-to-back → `o_READY` = 0 after 2 writes, the third operand is held upstream, and the head stays at 8'b0010_0000. Then release `i_READY` → outputs appear in order 1, 2, 3.
- Simultaneous read and write in ONE state, streaming 10 operands with `i_READY` = 1 → one result per cycle, count stays at 1, and the pointers wrap correctly.
- Assert `i_RST` while FULL → `o_VALID`, `o_READY`, `o_Y` and `o_err_cnt` go to 0 immediately, without waiting for a clock edge. After deassertion, `o_READY` = 1 and no stale entries emerge. Also drive 300 error operands → `o_err_cnt` saturates at 255.
